// File: rtl/rtype_encoder.sv
// Encodes alu_control + register fields into a MIPS R-type word, buffered in a DEPTH-entry FIFO.
// Define RTYPE_ENC_COUNT_EN to add the enc_count popped-word counter port.
module rtype_encoder #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_alu_control,
   input  logic [4:0]  in_rs,
   input  logic [4:0]  in_rt,
   input  logic [4:0]  in_rd,
   input  logic [4:0]  in_shamt,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic        err_illegal,
   output logic [3:0]  err_code,
   input  logic        err_clr
`ifdef RTYPE_ENC_COUNT_EN
   ,
   output logic [15:0] enc_count
`endif
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   logic [31:0]   mem_reg [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;
   logic          up_reg;
   logic          err_illegal_reg;
   logic [3:0]    err_code_reg;

   logic [5:0]    funct;
   logic          legal;
   logic          is_shift;
   logic [31:0]   word;
   logic          full;
   logic          accept;
   logic          push;
   logic          pop;

   always_comb begin
      funct    = 6'b000000;
      legal    = 1'b1;
      is_shift = 1'b0;
      case (in_alu_control)
         4'b0000: funct = 6'b100100;
         4'b0001: funct = 6'b100101;
         4'b0010: funct = 6'b100000;
         4'b0011: funct = 6'b100111;
         4'b0100: funct = 6'b100110;
         4'b0110: funct = 6'b100010;
         4'b0111: funct = 6'b101010;
         4'b1001: funct = 6'b011000;
         4'b1010: begin funct = 6'b000000; is_shift = 1'b1; end
         4'b1101: begin funct = 6'b000010; is_shift = 1'b1; end
         4'b1110: funct = 6'b101011;
         4'b1111: begin funct = 6'b000011; is_shift = 1'b1; end
         default: legal = 1'b0;
      endcase
   end

   // Shifts take their amount from shamt and ignore rs; everything else the reverse.
   assign word = {6'b000000, (is_shift ? 5'd0 : in_rs), in_rt, in_rd,
                  (is_shift ? in_shamt : 5'd0), funct};

   // up_reg holds in_ready low during reset and until the first edge afterwards.
   assign full      = (count_reg == CW'(DEPTH));
   assign in_ready  = up_reg & ~full;
   assign out_valid = (count_reg != '0);
   assign out_instr = mem_reg[rd_ptr_reg];
   assign accept    = in_valid & in_ready;
   assign push      = accept & legal;
   assign pop       = out_valid & out_ready;

   assign err_illegal = err_illegal_reg;
   assign err_code    = err_code_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         up_reg     <= 1'b0;
      end else begin
         up_reg <= 1'b1;
         if (push) begin
            mem_reg[wr_ptr_reg] <= word;
            wr_ptr_reg          <= wr_ptr_reg + 1'b1;
         end
         if (pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // A new illegal accept beats err_clr; only the first code since clear is kept.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_illegal_reg <= 1'b0;
         err_code_reg    <= 4'b0000;
      end else if (accept && !legal) begin
         err_illegal_reg <= 1'b1;
         if (!err_illegal_reg || err_clr) err_code_reg <= in_alu_control;
      end else if (err_clr) begin
         err_illegal_reg <= 1'b0;
         err_code_reg    <= 4'b0000;
      end
   end

`ifdef RTYPE_ENC_COUNT_EN
   logic [15:0] enc_count_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) enc_count_reg <= 16'h0000;
      else if (pop) enc_count_reg <= enc_count_reg + 16'h0001;
   end

   assign enc_count = enc_count_reg;
`endif

endmodule

// File: tb/tb_rtype_encoder.sv
// Directed testbench for rtype_encoder: encoding, FIFO flow control, error flags, reset.
module tb_rtype_encoder;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  in_alu_control = 4'b0;
   logic [4:0]  in_rs = 5'd0;
   logic [4:0]  in_rt = 5'd0;
   logic [4:0]  in_rd = 5'd0;
   logic [4:0]  in_shamt = 5'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic        err_illegal;
   logic [3:0]  err_code;
   logic        err_clr = 1'b0;
`ifdef RTYPE_ENC_COUNT_EN
   logic [15:0] enc_count;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rtype_encoder #(.DEPTH(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_alu_control(in_alu_control), .in_rs(in_rs), .in_rt(in_rt),
      .in_rd(in_rd), .in_shamt(in_shamt),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .err_illegal(err_illegal), .err_code(err_code), .err_clr(err_clr)
`ifdef RTYPE_ENC_COUNT_EN
      , .enc_count(enc_count)
`endif
   );

   // Independent funct -> alu_control decoder; 5'h10 marks an unknown funct.
   function automatic logic [4:0] alu_of_funct(input logic [5:0] f);
      case (f)
         6'b100100: return 5'h0;
         6'b100101: return 5'h1;
         6'b100000: return 5'h2;
         6'b100111: return 5'h3;
         6'b100110: return 5'h4;
         6'b100010: return 5'h6;
         6'b101010: return 5'h7;
         6'b011000: return 5'h9;
         6'b000000: return 5'hA;
         6'b000010: return 5'hD;
         6'b101011: return 5'hE;
         6'b000011: return 5'hF;
         default:   return 5'h10;
      endcase
   endfunction

   function automatic logic [31:0] add_word(input int rd);
      return 32'h00000020 | (32'(rd) << 11);
   endfunction

   task automatic set_req(input logic [3:0] c, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [4:0] sh);
      in_alu_control = c; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
   endtask

   task automatic send(input logic [3:0] c, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh);
      set_req(c, rs, rt, rd, sh);
      in_valid = 1'b1;
      $display("txn: code=%b rs=%0d rt=%0d rd=%0d shamt=%0d in_ready=%b", c, rs, rt, rd, sh, in_ready);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic apply_reset();
      in_valid = 1'b0; err_clr = 1'b0; out_ready = 1'b0;
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (out_valid !== 1'b0 || out_instr !== 32'h0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: valid=%b instr=%h ready=%b, want 0 0 0", out_valid, out_instr, in_ready);
      end
      checks++;
      if (err_illegal !== 1'b0 || err_code !== 4'h0) begin
         errors++;
         $display("FAIL reset_err: illegal=%b code=%h, want 0 0", err_illegal, err_code);
      end
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: ready=%b valid=%b, want 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_encode();
      out_ready = 1'b1;
      send(4'b0010, 5'd1, 5'd2, 5'd3, 5'd7);
      checks++;
      if (out_valid !== 1'b1 || out_instr !== 32'h00221820) begin
         errors++;
         $display("FAIL encode_add: valid=%b instr=%h, want 1 00221820", out_valid, out_instr);
      end
      send(4'b1010, 5'd5, 5'd2, 5'd4, 5'd3);
      checks++;
      if (out_valid !== 1'b1 || out_instr !== 32'h000220C0) begin
         errors++;
         $display("FAIL encode_sll: valid=%b instr=%h, want 1 000220c0", out_valid, out_instr);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL encode_drain: valid=%b, want 0", out_valid);
      end
   endtask

   task automatic test_full();
      int acc_k;
      logic take;
      acc_k = -1;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(4'b0010, 5'd0, 5'd0, 5'(i), 5'd0);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_instr !== add_word(0)) begin
         errors++;
         $display("FAIL full_flag: ready=%b valid=%b instr=%h, want 0 1 %h", in_ready, out_valid, out_instr, add_word(0));
      end
      set_req(4'b0010, 5'd0, 5'd0, 5'd4, 5'd0);
      in_valid = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b0 || out_instr !== add_word(0)) begin
         errors++;
         $display("FAIL full_stall: ready=%b instr=%h, want 0 %h", in_ready, out_instr, add_word(0));
      end
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (out_valid !== 1'b1 || out_instr !== add_word(k)) begin
            errors++;
            $display("FAIL full_order%0d: valid=%b instr=%h, want 1 %h", k, out_valid, out_instr, add_word(k));
         end
         take = in_valid & in_ready;
         $display("txn: pop %0d instr=%h accept5=%b", k, out_instr, take);
         @(posedge clk); #1;
         if (take) begin
            in_valid = 1'b0;
            acc_k = k;
         end
      end
      checks++;
      if (acc_k != 1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL full_fifth_accept: accepted at pop %0d valid=%b, want pop 1 valid 0", acc_k, out_valid);
      end
      in_valid = 1'b0;
   endtask

   task automatic test_illegal();
      out_ready = 1'b1;
      send(4'b1000, 5'd1, 5'd1, 5'd1, 5'd1);
      send(4'b1100, 5'd1, 5'd1, 5'd1, 5'd1);
      checks++;
      if (out_valid !== 1'b0 || err_illegal !== 1'b1 || err_code !== 4'b1000) begin
         errors++;
         $display("FAIL illegal_first: valid=%b err=%b code=%b, want 0 1 1000", out_valid, err_illegal, err_code);
      end
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      checks++;
      if (err_illegal !== 1'b0 || err_code !== 4'b0000) begin
         errors++;
         $display("FAIL illegal_clear: err=%b code=%b, want 0 0000", err_illegal, err_code);
      end
      send(4'b1011, 5'd0, 5'd0, 5'd0, 5'd0);
      err_clr = 1'b1;
      send(4'b0101, 5'd0, 5'd0, 5'd0, 5'd0);
      err_clr = 1'b0;
      checks++;
      if (err_illegal !== 1'b1 || err_code !== 4'b0101 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL illegal_clr_collide: err=%b code=%b valid=%b, want 1 0101 0", err_illegal, err_code, out_valid);
      end
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
   endtask

   task automatic test_roundtrip();
      logic [3:0] codes [12] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6,
                                  4'h7, 4'h9, 4'hA, 4'hD, 4'hE, 4'hF};
      logic shift;
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         send(codes[i], 5'd3, 5'd4, 5'd5, 5'd6);
         shift = (codes[i] == 4'hA) || (codes[i] == 4'hD) || (codes[i] == 4'hF);
         checks++;
         if (out_valid !== 1'b1 || alu_of_funct(out_instr[5:0]) !== {1'b0, codes[i]}) begin
            errors++;
            $display("FAIL roundtrip_%h: valid=%b funct=%b, want 1 decode to %h", codes[i], out_valid, out_instr[5:0], codes[i]);
         end
         checks++;
         if (out_instr[31:26] !== 6'd0 || out_instr[20:11] !== {5'd4, 5'd5} ||
             out_instr[25:21] !== (shift ? 5'd0 : 5'd3) || out_instr[10:6] !== (shift ? 5'd6 : 5'd0)) begin
            errors++;
            $display("FAIL fields_%h: instr=%h, want op0 rs=%0d rt=4 rd=5 shamt=%0d", codes[i], out_instr, shift ? 0 : 3, shift ? 6 : 0);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         set_req(4'b0001, 5'(i + 1), 5'd0, 5'(i), 5'd0);
         in_valid = 1'b1;
         @(posedge clk); #1;
         $display("txn: b2b %0d instr=%h", i, out_instr);
         checks++;
         if (out_valid !== 1'b1 || out_instr !== ((32'(i + 1) << 21) | (32'(i) << 11) | 32'h25)) begin
            errors++;
            $display("FAIL b2b_%0d: valid=%b instr=%h, want 1 %h", i, out_valid, out_instr,
                     (32'(i + 1) << 21) | (32'(i) << 11) | 32'h25);
         end
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_drain: valid=%b, want 0", out_valid);
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      out_ready = 1'b1;
      send(4'b0010, 5'd0, 5'd0, 5'd1, 5'd0);
      send(4'b0010, 5'd0, 5'd0, 5'd2, 5'd0);
      @(posedge clk); #1;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(4'b0010, 5'd0, 5'd0, 5'(i + 8), 5'd0);
      checks++;
      if (out_valid !== 1'b1 || out_instr !== add_word(8)) begin
         errors++;
         $display("FAIL mid_buffered: valid=%b instr=%h, want 1 %h", out_valid, out_instr, add_word(8));
      end
`ifdef RTYPE_ENC_COUNT_EN
      checks++;
      if (enc_count !== 16'd2) begin
         errors++;
         $display("FAIL enc_count_pops: count=%0d, want 2", enc_count);
      end
`endif
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_instr !== 32'h0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_async: valid=%b instr=%h ready=%b, want 0 0 0", out_valid, out_instr, in_ready);
      end
`ifdef RTYPE_ENC_COUNT_EN
      checks++;
      if (enc_count !== 16'd0) begin
         errors++;
         $display("FAIL enc_count_reset: count=%0d, want 0", enc_count);
      end
`endif
      @(posedge clk); #1 reset_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_release: valid=%b ready=%b, want 0 1", out_valid, in_ready);
      end
   endtask

   initial begin
      test_reset();
      test_encode();
      test_full();
      test_illegal();
      test_roundtrip();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
